// File: rtl/ifetch_req_if.sv
`default_nettype none
// ============================================================================
// Module : ifetch_req_if
// Brief  : Instruction-bus request/response bundle between fetch and memory.
// Rev    : 1.0 - initial release
// ============================================================================
interface ifetch_req_if;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;

    modport master (
        output ireq_valid,
        output ireq_addr,
        input  iresp_data_ok,
        input  iresp_data
    );

    modport slave (
        input  ireq_valid,
        input  ireq_addr,
        output iresp_data_ok,
        output iresp_data
    );
endinterface
`default_nettype wire

// File: rtl/ifetch_req.sv
`default_nettype none
// ============================================================================
// Module : ifetch_req
// Brief  : Fetch-PC owner; issues one ibus read at a time and buffers the word.
// Rev    : 1.0 - initial release
// ============================================================================
module ifetch_req #(
    parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
    input  logic         clk,
    input  logic         reset,
    ifetch_req_if.master ibus,
    input  logic         stall,
    input  logic         redirect_valid,
    input  logic [63:0]  redirect_pc,
    output logic [31:0]  raw_instr,
    output logic [63:0]  pc,
    output logic         ivalid,
    output logic         Iwait
);

    typedef enum logic [1:0] {
        S_BOOT    = 2'd0,
        S_REQ     = 2'd1,
        S_DISCARD = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_fetch_pc;
    logic [63:0] w_fetch_pc_nxt;
    logic [63:0] r_pend_pc;
    logic [63:0] w_pend_pc_nxt;
    logic [63:0] r_pc;
    logic [63:0] w_pc_nxt;
    logic [31:0] r_raw_instr;
    logic [31:0] w_raw_instr_nxt;
    logic        r_ivalid;
    logic        w_ivalid_nxt;
    logic        w_req;
    logic [63:0] w_redir_pc;

    // Redirect targets are word aligned regardless of the low bits supplied.
    assign w_redir_pc = redirect_pc & ~64'd3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_BOOT;
            r_fetch_pc  <= PC_RESET;
            r_pend_pc   <= 64'd0;
            r_pc        <= 64'd0;
            r_raw_instr <= 32'd0;
            r_ivalid    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fetch_pc  <= w_fetch_pc_nxt;
            r_pend_pc   <= w_pend_pc_nxt;
            r_pc        <= w_pc_nxt;
            r_raw_instr <= w_raw_instr_nxt;
            r_ivalid    <= w_ivalid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_fetch_pc_nxt  = r_fetch_pc;
        w_pend_pc_nxt   = r_pend_pc;
        w_pc_nxt        = r_pc;
        w_raw_instr_nxt = r_raw_instr;
        w_ivalid_nxt    = r_ivalid;
        w_req           = 1'b0;

        case (r_state)
            S_BOOT: begin
                if (redirect_valid) begin
                    w_fetch_pc_nxt = w_redir_pc;
                end
                w_state_nxt = S_REQ;
            end

            S_REQ: begin
                w_req = 1'b1;
                if (ibus.iresp_data_ok) begin
                    if (redirect_valid) begin
                        w_fetch_pc_nxt = w_redir_pc;
                    end else begin
                        w_raw_instr_nxt = ibus.iresp_data;
                        w_pc_nxt        = r_fetch_pc;
                        w_ivalid_nxt    = 1'b1;
                        w_state_nxt     = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    // The request cannot be withdrawn; remember where to go once it retires.
                    w_pend_pc_nxt = w_redir_pc;
                    w_state_nxt   = S_DISCARD;
                end
            end

            S_DISCARD: begin
                w_req = 1'b1;
                if (redirect_valid) begin
                    w_pend_pc_nxt = w_redir_pc;
                end
                if (ibus.iresp_data_ok) begin
                    w_fetch_pc_nxt = redirect_valid ? w_redir_pc : r_pend_pc;
                    w_state_nxt    = S_REQ;
                end
            end

            S_HOLD: begin
                if (redirect_valid) begin
                    w_ivalid_nxt   = 1'b0;
                    w_fetch_pc_nxt = w_redir_pc;
                    w_state_nxt    = S_REQ;
                end else if (!stall) begin
                    w_ivalid_nxt   = 1'b0;
                    w_fetch_pc_nxt = r_fetch_pc + 64'd4;
                    w_state_nxt    = S_REQ;
                end
            end

            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    assign ibus.ireq_valid = w_req;
    assign ibus.ireq_addr  = r_fetch_pc;
    assign Iwait           = w_req & ~ibus.iresp_data_ok;
    assign raw_instr       = r_raw_instr;
    assign pc              = r_pc;
    assign ivalid          = r_ivalid;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_req.sv
`default_nettype none
// ============================================================================
// Module : tb_ifetch_req
// Brief  : Scoreboard bench for ifetch_req with a latency-programmable ibus responder.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_ifetch_req;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [31:0] raw_instr;
    logic [63:0] pc;
    logic        ivalid;
    logic        Iwait;

    int checks = 0;
    int errors = 0;
    int lat = 0;
    logic spurious = 1'b0;

    logic [63:0] exp_req[$];
    logic [95:0] exp_ins[$];

    ifetch_req_if ibus ();

    ifetch_req #(.PC_RESET(64'h0000_0000_8000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .ibus           (ibus),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .raw_instr      (raw_instr),
        .pc             (pc),
        .ivalid         (ivalid),
        .Iwait          (Iwait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory responder: data_ok after 'lat' wait cycles; word = addr[31:0] ^ 32'h8000_0013.
    initial begin
        int cnt;
        cnt = 0;
        ibus.iresp_data_ok = 1'b0;
        ibus.iresp_data    = 32'd0;
        forever begin
            @(negedge clk);
            if (ibus.ireq_valid) begin
                if (cnt >= lat) begin
                    ibus.iresp_data_ok = 1'b1;
                    ibus.iresp_data    = ibus.ireq_addr[31:0] ^ 32'h8000_0013;
                    cnt = 0;
                end else begin
                    ibus.iresp_data_ok = 1'b0;
                    ibus.iresp_data    = 32'd0;
                    cnt++;
                end
            end else begin
                ibus.iresp_data_ok = spurious;
                ibus.iresp_data    = spurious ? 32'hDEAD_BEEF : 32'd0;
                cnt = 0;
            end
        end
    end

    // Monitor: pops expected requests/instructions as the DUT presents them.
    initial begin
        logic        prev_out;
        logic        prev_iv;
        logic [63:0] prev_addr;
        logic [31:0] h_raw;
        logic [63:0] h_pc;
        logic [95:0] e;
        prev_out = 1'b0; prev_iv = 1'b0; prev_addr = '0; h_raw = '0; h_pc = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                prev_out = 1'b0;
                prev_iv  = 1'b0;
            end else begin
                chk("iwait", {63'd0, Iwait}, {63'd0, ibus.ireq_valid & ~ibus.iresp_data_ok});
                if (ibus.ireq_valid && !prev_out) begin
                    if (exp_req.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL req_unexpected: got addr %h expected no request", ibus.ireq_addr);
                    end else begin
                        chk("req_addr", ibus.ireq_addr, exp_req.pop_front());
                    end
                end else if (ibus.ireq_valid && prev_out) begin
                    chk("req_addr_stable", ibus.ireq_addr, prev_addr);
                end
                if (ivalid && !prev_iv) begin
                    if (exp_ins.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL ins_unexpected: got pc %h instr %h expected none", pc, raw_instr);
                    end else begin
                        e = exp_ins.pop_front();
                        chk("ins_pc", pc, e[95:32]);
                        chk("ins_raw", {32'd0, raw_instr}, {32'd0, e[31:0]});
                    end
                    h_raw = raw_instr;
                    h_pc  = pc;
                end else if (ivalid && prev_iv) begin
                    chk("hold_pc", pc, h_pc);
                    chk("hold_raw", {32'd0, raw_instr}, {32'd0, h_raw});
                end
                prev_out  = ibus.ireq_valid & ~ibus.iresp_data_ok;
                prev_iv   = ivalid;
                prev_addr = ibus.ireq_addr;
            end
        end
    end

    task automatic wait_ins_done(input int budget);
        int n = 0;
        while (exp_ins.size() != 0 && n < budget) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (exp_ins.size() != 0) begin
            checks++; errors++;
            $display("FAIL ins_timeout: got %0d pending expected 0", exp_ins.size());
            exp_ins.delete();
        end
    endtask

    task automatic wait_req_start(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            #3;
            n++;
        end while (!ibus.ireq_valid && n < budget);
        if (!ibus.ireq_valid) begin
            checks++; errors++;
            $display("FAIL req_timeout: got ireq_valid 0 expected 1");
        end
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (3) @(negedge clk);
        #3;
        chk("rst_ireq_valid", {63'd0, ibus.ireq_valid}, 64'd0);
        chk("rst_iwait", {63'd0, Iwait}, 64'd0);
        chk("rst_ivalid", {63'd0, ivalid}, 64'd0);
        chk("rst_pc", pc, 64'd0);
        chk("rst_raw", {32'd0, raw_instr}, 64'd0);

        // Zero-latency streaming
        lat = 0;
        exp_req.push_back(64'h8000_0000); exp_ins.push_back({64'h8000_0000, 32'h0000_0013});
        exp_req.push_back(64'h8000_0004); exp_ins.push_back({64'h8000_0004, 32'h0000_0017});
        exp_req.push_back(64'h8000_0008); exp_ins.push_back({64'h8000_0008, 32'h0000_001B});
        reset = 1'b1;
        wait_ins_done(40);
        stall = 1'b1;

        // Held under stall, including stray data_ok with no request
        spurious = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #3;
            chk("hold_noreq", {63'd0, ibus.ireq_valid}, 64'd0);
            chk("hold_ivalid", {63'd0, ivalid}, 64'd1);
        end
        spurious = 1'b0;
        lat = 3;
        exp_req.push_back(64'h8000_000C); exp_ins.push_back({64'h8000_000C, 32'h0000_001F});
        stall = 1'b0;
        wait_ins_done(40);
        stall = 1'b1;

        // Single redirect one cycle into a slow request
        exp_req.push_back(64'h8000_0010);
        exp_req.push_back(64'h8000_1000); exp_ins.push_back({64'h8000_1000, 32'h0000_1013});
        stall = 1'b0;
        wait_req_start(20);
        @(negedge clk); #3;
        chk("iwait_inflight", {63'd0, Iwait}, 64'd1);
        redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
        @(negedge clk); #3;
        redirect_valid = 1'b0;
        chk("discard_addr", ibus.ireq_addr, 64'h8000_0010);
        chk("discard_ivalid", {63'd0, ivalid}, 64'd0);
        wait_ins_done(40);
        stall = 1'b1;

        // Two redirects, the latest lands in DISCARD
        exp_req.push_back(64'h8000_1004);
        exp_req.push_back(64'h8000_2000); exp_ins.push_back({64'h8000_2000, 32'h0000_2013});
        stall = 1'b0;
        wait_req_start(20);
        @(negedge clk); #3;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
        @(negedge clk); #3;
        redirect_pc = 64'h8000_2000;
        @(negedge clk); #3;
        redirect_valid = 1'b0;
        wait_ins_done(40);
        stall = 1'b1;

        // Redirect with misaligned target while stalled in HOLD
        lat = 1;
        exp_req.push_back(64'h8000_0100); exp_ins.push_back({64'h8000_0100, 32'h0000_0113});
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0103;
        @(negedge clk); #3;
        redirect_valid = 1'b0;
        chk("redir_ivalid_drop", {63'd0, ivalid}, 64'd0);
        chk("redir_addr", ibus.ireq_addr, 64'h8000_0100);
        wait_ins_done(40);

        // PC wrap at the top of the address space
        lat = 0;
        exp_req.push_back(64'hFFFF_FFFF_FFFF_FFFC); exp_ins.push_back({64'hFFFF_FFFF_FFFF_FFFC, 32'h7FFF_FFEF});
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        @(negedge clk); #3;
        redirect_valid = 1'b0;
        wait_ins_done(40);
        exp_req.push_back(64'h0000_0000_0000_0000); exp_ins.push_back({64'h0, 32'h8000_0013});
        stall = 1'b0;
        wait_ins_done(40);
        stall = 1'b1;

        // Reset asserted while waiting on a response
        lat = 5;
        exp_req.push_back(64'h0000_0000_0000_0004);
        stall = 1'b0;
        wait_req_start(20);
        stall = 1'b1;
        @(negedge clk); #3;
        chk("iwait_before_rst", {63'd0, Iwait}, 64'd1);
        reset = 1'b0;
        #1;
        chk("midrst_ireq_valid", {63'd0, ibus.ireq_valid}, 64'd0);
        chk("midrst_iwait", {63'd0, Iwait}, 64'd0);
        chk("midrst_ivalid", {63'd0, ivalid}, 64'd0);
        chk("midrst_pc", pc, 64'd0);
        lat = 3;
        repeat (2) @(negedge clk);
        #3;
        exp_req.push_back(64'h8000_0000); exp_ins.push_back({64'h8000_0000, 32'h0000_0013});
        reset = 1'b1;
        wait_ins_done(40);
        repeat (2) @(negedge clk);
        #3;
        chk("req_queue_drained", exp_req.size(), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
